// File: rtl/imem_loader.sv
// Byte-stream program loader: packs big-endian words from a valid/ready byte stream
// into instruction memory and holds the CPU until the whole image has been written.
module imem_loader #(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int          MAX_WORDS      = 256,
    parameter int          TIMEOUT_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error,
    output logic [15:0] words_left
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_t;

    localparam int          TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [16:0] MAX_LEN   = 17'(MAX_WORDS);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t        state;
    state_t        state_next;
    logic [7:0]    len_hi;
    logic [1:0]    byte_idx;
    logic [TW-1:0] timer;
    logic          accept;
    logic [15:0]   len_word;
    logic          len_too_big;
    logic          timer_expired;

    assign accept        = byte_valid && byte_ready;
    assign len_word      = {len_hi, byte_data};
    assign len_too_big   = {1'b0, len_word} > MAX_LEN;
    // An idle cycle with the timer at TIMEOUT_CYCLES-1 is the TIMEOUT_CYCLES-th idle cycle.
    assign timer_expired = !accept && (timer == TIMER_LAST);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE, S_DONE, S_ERROR: if (start) state_next = S_LEN_HI;
            S_LEN_HI: if (accept) state_next = S_LEN_LO;
            S_LEN_LO: begin
                if (accept) begin
                    if (len_word == 16'd0) state_next = S_DONE;
                    else if (len_too_big)  state_next = S_ERROR;
                    else                   state_next = S_DATA;
                end else if (timer_expired) begin
                    state_next = S_ERROR;
                end
            end
            S_DATA: begin
                if (accept && byte_idx == 2'd3) state_next = S_WRITE;
                else if (timer_expired)         state_next = S_ERROR;
            end
            S_WRITE: state_next = (words_left == 16'd1) ? S_DONE : S_DATA;
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: non-blocking (<=) in clocked blocks so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr   <= BASE_ADDR;
            mem_wdata  <= 32'd0;
            words_left <= 16'd0;
            len_hi     <= 8'd0;
            byte_idx   <= 2'd0;
            timer      <= '0;
        end else begin
            // Counts only while waiting in LEN_LO/DATA; cleared by accepts and state changes.
            if ((state == S_LEN_LO || state == S_DATA) && !accept && state_next == state)
                timer <= timer + TW'(1);
            else
                timer <= '0;

            unique case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        mem_addr <= BASE_ADDR;
                        byte_idx <= 2'd0;
                    end
                end
                S_LEN_HI: if (accept) len_hi <= byte_data;
                S_LEN_LO: if (accept && !len_too_big) words_left <= len_word;
                S_DATA: begin
                    if (accept) begin
                        mem_wdata <= {mem_wdata[23:0], byte_data};
                        byte_idx  <= byte_idx + 2'd1;
                    end
                end
                S_WRITE: begin
                    mem_addr   <= mem_addr + 32'd4;
                    words_left <= words_left - 16'd1;
                end
                default: ;
            endcase
        end
    end

    // NOTE: defaults first so every path assigns every output; nothing becomes a latch.
    always_comb begin
        byte_ready = 1'b0;
        mem_we     = 1'b0;
        cpu_hold   = 1'b1;
        done       = 1'b0;
        error      = 1'b0;
        unique case (state)
            S_LEN_HI, S_LEN_LO, S_DATA: byte_ready = 1'b1;
            S_WRITE:                    mem_we     = 1'b1;
            S_DONE: begin
                cpu_hold = 1'b0;
                done     = 1'b1;
            end
            S_ERROR:                    error      = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a table of whole-image loads plus hand-written
// sequences for timeout, reset abort, ignored start and the MAX_WORDS boundary.
module tb_imem_loader;

    localparam logic [31:0] BASE    = 32'h0000_0000;
    localparam int          MAXW    = 256;
    localparam int          TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [15:0] words_left;

    imem_loader #(
        .BASE_ADDR     (BASE),
        .MAX_WORDS     (MAXW),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .byte_ready(byte_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .error     (error),
        .words_left(words_left)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];

    typedef struct {
        logic [15:0] len;
        int          nsent;
        logic [31:0] w[4];
        int          gap_max;
        bit          gap_rand;
        bit          exp_done;
        int          exp_writes;
        int          exp_wait;
    } vec_t;

    localparam int NVEC = 6;
    vec_t vecs[NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // Every write strobe is logged once per cycle; the loader must never be ready then.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
            check("ready_low_in_write", {31'd0, byte_ready}, 32'd0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic set_vec(input int idx, input logic [15:0] len, input int nsent,
                           input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] w2, input logic [31:0] w3,
                           input int gap_max, input bit gap_rand, input bit exp_done,
                           input int exp_writes, input int exp_wait);
        vecs[idx].len        = len;
        vecs[idx].nsent      = nsent;
        vecs[idx].w[0]       = w0;
        vecs[idx].w[1]       = w1;
        vecs[idx].w[2]       = w2;
        vecs[idx].w[3]       = w3;
        vecs[idx].gap_max    = gap_max;
        vecs[idx].gap_rand   = gap_rand;
        vecs[idx].exp_done   = exp_done;
        vecs[idx].exp_writes = exp_writes;
        vecs[idx].exp_wait   = exp_wait;
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic send_byte(input logic [7:0] b);
        int budget = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (!byte_ready) check("ready_wait", {31'd0, byte_ready}, 32'd1);
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int b = 3; b >= 0; b--) send_byte(w[8*b +: 8]);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(output int k);
        k = 0;
        while (!(done || error) && k < 40) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
    endtask

    initial begin
        int k;
        int g;

        set_vec(0, 16'h0002, 2, 32'h2008_0005, 32'hAC08_0004, 32'h0, 32'h0, 0, 1'b0, 1'b1, 2, 1);
        set_vec(1, 16'h0000, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 1'b0, 1'b1, 0, 0);
        set_vec(2, 16'h0101, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 1'b0, 1'b0, 0, 0);
        set_vec(3, 16'h0004, 4, 32'h0102_0304, 32'h5566_7788, 32'h9ABC_DEF0, 32'h0F1E_2D3C,
                TIMEOUT - 1, 1'b1, 1'b1, 4, 1);
        set_vec(4, 16'h0001, 1, 32'hCAFE_F00D, 32'h0, 32'h0, 32'h0, TIMEOUT - 1, 1'b0, 1'b1, 1, 1);
        set_vec(5, 16'h8001, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 1'b0, 1'b0, 0, 0);

        rst        = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        idle(2);
        check("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
        check("rst_mem_we",     {31'd0, mem_we},     32'd0);
        check("rst_mem_addr",   mem_addr,            BASE);
        check("rst_mem_wdata",  mem_wdata,           32'd0);
        check("rst_cpu_hold",   {31'd0, cpu_hold},   32'd1);
        check("rst_done",       {31'd0, done},       32'd0);
        check("rst_error",      {31'd0, error},      32'd0);
        check("rst_words_left", {16'd0, words_left}, 32'd0);
        rst = 1'b0;
        idle(1);

        for (int v = 0; v < NVEC; v++) begin
            clear_log();
            pulse_start();
            check($sformatf("v%0d_hold_after_start", v), {31'd0, cpu_hold}, 32'd1);
            check($sformatf("v%0d_done_after_start", v), {31'd0, done}, 32'd0);
            check($sformatf("v%0d_ready_len_hi", v), {31'd0, byte_ready}, 32'd1);
            send_byte(vecs[v].len[15:8]);
            send_byte(vecs[v].len[7:0]);
            for (int i = 0; i < vecs[v].nsent; i++) begin
                for (int b = 3; b >= 0; b--) begin
                    g = vecs[v].gap_rand ? int'($urandom_range(0, vecs[v].gap_max)) : vecs[v].gap_max;
                    idle(g);
                    send_byte(vecs[v].w[i][8*b +: 8]);
                end
                // The write cycle directly follows the 4th accept.
                check($sformatf("v%0d_w%0d_we", v, i), {31'd0, mem_we}, 32'd1);
                check($sformatf("v%0d_w%0d_addr_now", v, i), mem_addr, BASE + 32'(4 * i));
                check($sformatf("v%0d_w%0d_data_now", v, i), mem_wdata, vecs[v].w[i]);
            end
            wait_end(k);
            check($sformatf("v%0d_latency", v), k, vecs[v].exp_wait);
            check($sformatf("v%0d_done", v), {31'd0, done}, {31'd0, vecs[v].exp_done});
            check($sformatf("v%0d_error", v), {31'd0, error}, {31'd0, !vecs[v].exp_done});
            check($sformatf("v%0d_cpu_hold", v), {31'd0, cpu_hold}, {31'd0, !vecs[v].exp_done});
            check($sformatf("v%0d_nwrites", v), wr_addr.size(), vecs[v].exp_writes);
            for (int i = 0; i < wr_addr.size() && i < vecs[v].exp_writes; i++) begin
                check($sformatf("v%0d_wr%0d_addr", v, i), wr_addr[i], BASE + 32'(4 * i));
                check($sformatf("v%0d_wr%0d_data", v, i), wr_data[i], vecs[v].w[i]);
            end
            if (vecs[v].exp_done)
                check($sformatf("v%0d_words_left", v), {16'd0, words_left}, 32'd0);
        end

        // Timeout after three data bytes: error on exactly the TIMEOUT-th idle cycle.
        clear_log();
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'hDE);
        send_byte(8'hAD);
        send_byte(8'hBE);
        check("to_no_error_yet", {31'd0, error}, 32'd0);
        k = 0;
        while (!error && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("to_idle_cycles", k, TIMEOUT);
        check("to_error", {31'd0, error}, 32'd1);
        check("to_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        check("to_nwrites", wr_addr.size(), 0);
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h01);
        send_word(32'h1357_9BDF);
        wait_end(k);
        check("to_reload_done", {31'd0, done}, 32'd1);
        check("to_reload_nwrites", wr_addr.size(), 1);
        if (wr_addr.size() == 1) begin
            check("to_reload_addr", wr_addr[0], BASE);
            check("to_reload_data", wr_data[0], 32'h1357_9BDF);
        end

        // MAX_WORDS itself is accepted.
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h00);
        check("max_ready", {31'd0, byte_ready}, 32'd1);
        check("max_error", {31'd0, error}, 32'd0);
        check("max_words_left", {16'd0, words_left}, 32'd256);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;

        // start mid-DATA is ignored; the word continues from where it was.
        clear_log();
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h11);
        send_byte(8'h22);
        pulse_start();
        check("mid_start_ready", {31'd0, byte_ready}, 32'd1);
        check("mid_start_words_left", {16'd0, words_left}, 32'd1);
        send_byte(8'h33);
        send_byte(8'h44);
        check("mid_start_we", {31'd0, mem_we}, 32'd1);
        check("mid_start_data", mem_wdata, 32'h1122_3344);
        check("mid_start_addr", mem_addr, BASE);
        wait_end(k);
        check("mid_start_done", {31'd0, done}, 32'd1);

        // Reset after two data bytes aborts without a write.
        clear_log();
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'hAA);
        send_byte(8'hBB);
        rst = 1'b1;
        idle(1);
        check("abort_ready", {31'd0, byte_ready}, 32'd0);
        check("abort_hold", {31'd0, cpu_hold}, 32'd1);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_error", {31'd0, error}, 32'd0);
        check("abort_words_left", {16'd0, words_left}, 32'd0);
        check("abort_addr", mem_addr, BASE);
        check("abort_wdata", mem_wdata, 32'd0);
        rst = 1'b0;
        idle(2);
        check("abort_nwrites", wr_addr.size(), 0);
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h01);
        send_word(32'h0BAD_C0DE);
        wait_end(k);
        check("after_abort_done", {31'd0, done}, 32'd1);
        check("after_abort_nwrites", wr_addr.size(), 1);
        if (wr_addr.size() == 1) begin
            check("after_abort_addr", wr_addr[0], BASE);
            check("after_abort_data", wr_data[0], 32'h0BAD_C0DE);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
